// File: rtl/codix_regfile_mp_if.sv
// Port bundle for codix_regfile_mp: read (Q/RA/RE) and write (D/WA/WE) groups,
// flattened per port exactly like the legacy pin style.
interface codix_regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 1
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [NUM_RD*AW-1:0]    RA;
  logic [NUM_RD-1:0]       RE;
  logic [NUM_RD*WIDTH-1:0] Q;
  logic [NUM_WR*AW-1:0]    WA;
  logic [NUM_WR*WIDTH-1:0] D;
  logic [NUM_WR-1:0]       WE;

  modport master (output RA, RE, WA, D, WE, input Q);
  modport slave  (input RA, RE, WA, D, WE, output Q);
endinterface

// File: rtl/codix_regfile_mp.sv
// Parametrised multi-port register file: flop array, priority write decode,
// registered read ports with hold, optional write-first bypass and zero register.
module codix_regfile_mp_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_WR   = 1,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         re,
  input  logic [AW-1:0]                ra,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*AW-1:0]         wa,
  input  logic [NUM_WR*WIDTH-1:0]      d,
  output logic [WIDTH-1:0]             q
);
  logic             hit;
  logic [WIDTH-1:0] byp;
  logic [WIDTH-1:0] val;

  // Ascending scan so the highest-index matching writer supplies bypass data.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j] && (wa[j*AW +: AW] == ra)) begin
        hit = 1'b1;
        byp = d[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    val = '0;
    if (32'(ra) >= DEPTH)              val = '0;
    else if (ZERO_REG != 0 && ra == '0) val = '0;
    else if (BYPASS != 0 && hit)        val = byp;
    else                                val = mem[ra];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     q <= '0;
    else if (re) q <= val;
  end
endmodule

module codix_regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  codix_regfile_mp_if.slave bus
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [DEPTH-1:0]             wen;
  logic [DEPTH-1:0][WIDTH-1:0]  wdat;
  logic [AW-1:0]                wa_c;
  logic [NUM_RD-1:0][WIDTH-1:0] q;

  // Later ports overwrite earlier decode results: highest index wins a conflict.
  always_comb begin
    wen  = '0;
    wdat = '0;
    wa_c = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa_c = bus.WA[j*AW +: AW];
      if (bus.WE[j] && (32'(wa_c) < DEPTH) && !(ZERO_REG != 0 && wa_c == '0)) begin
        wen[wa_c]  = 1'b1;
        wdat[wa_c] = bus.D[j*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mem <= '0;
    else begin
      for (int r = 0; r < DEPTH; r++)
        if (wen[r]) mem[r] <= wdat[r];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    codix_regfile_mp_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .AW(AW),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .CLK (CLK),
      .RST (RST),
      .re  (bus.RE[i]),
      .ra  (bus.RA[i*AW +: AW]),
      .mem (mem),
      .we  (bus.WE),
      .wa  (bus.WA),
      .d   (bus.D),
      .q   (q[i])
    );
  end

  assign bus.Q = q;
endmodule

// File: tb/tb_codix_regfile_mp.sv
// Directed + random check of two codix_regfile_mp configurations against an array model.
module tb_codix_regfile_mp;
  logic        CLK = 1'b0;
  logic        RST;
  logic [14:0] ra;
  logic [2:0]  re;
  logic [9:0]  wa;
  logic [63:0] d;
  logic [1:0]  we;

  int vectors = 0;
  int miscompares = 0;

  // dut 0: DEPTH 32, zero reg, bypass.  dut 1: DEPTH 24, no zero reg, read-first.
  int          depth_k [2] = '{32, 24};
  bit          zr_k    [2] = '{1'b1, 1'b0};
  bit          bp_k    [2] = '{1'b1, 1'b0};
  logic [31:0] mm [2][32];
  logic [31:0] qm [2][3];

  always #5 CLK = ~CLK;

  codix_regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(3), .NUM_WR(2)) ia ();
  codix_regfile_mp_if #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .NUM_WR(2)) ib ();

  assign ia.RA = ra; assign ia.RE = re; assign ia.WA = wa; assign ia.D = d; assign ia.WE = we;
  assign ib.RA = ra; assign ib.RE = re; assign ib.WA = wa; assign ib.D = d; assign ib.WE = we;

  codix_regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.CLK(CLK), .RST(RST), .bus(ia));
  codix_regfile_mp #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(0), .BYPASS(0))
    dut_b (.CLK(CLK), .RST(RST), .bus(ib));

  function automatic logic [31:0] dut_q(int k, int i);
    return (k == 0) ? ia.Q[i*32 +: 32] : ib.Q[i*32 +: 32];
  endfunction

  function automatic logic [31:0] ref_val(int k, int a);
    logic [31:0] v;
    if (a >= depth_k[k]) return 32'h0;
    if (zr_k[k] && a == 0) return 32'h0;
    v = mm[k][a];
    if (bp_k[k])
      for (int j = 0; j < 2; j++)
        if (we[j] && int'(wa[j*5 +: 5]) == a) v = d[j*32 +: 32];
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 32; a++) mm[k][a] = 32'h0;
      for (int i = 0; i < 3; i++) qm[k][i] = 32'h0;
    end
  endtask

  task automatic step();
    logic [31:0] nq [2][3];
    int a;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++)
        nq[k][i] = re[i] ? ref_val(k, int'(ra[i*5 +: 5])) : qm[k][i];
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++)
        if (we[j]) begin
          a = int'(wa[j*5 +: 5]);
          if (a < depth_k[k] && !(zr_k[k] && a == 0)) mm[k][a] = d[j*32 +: 32];
        end
    qm = nq;
    @(posedge CLK); #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++)
        chk($sformatf("dut%0d.q%0d", k, i), dut_q(k, i), qm[k][i]);
  endtask

  task automatic rst_pulse();
    #2 RST = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++)
        chk($sformatf("rst.dut%0d.q%0d", k, i), dut_q(k, i), 32'h0);
    model_clear();
    #1 RST = 1'b0;
  endtask

  task automatic idle();
    we = '0;
    re = '0;
  endtask

  task automatic wr(int j, int a, logic [31:0] v);
    we[j] = 1'b1;
    wa[j*5 +: 5] = 5'(a);
    d[j*32 +: 32] = v;
  endtask

  task automatic rd(int i, int a);
    re[i] = 1'b1;
    ra[i*5 +: 5] = 5'(a);
  endtask

  initial begin
    int a;
    RST = 1'b1; ra = '0; re = '0; wa = '0; d = '0; we = '0;
    model_clear();
    #12;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++)
        chk($sformatf("init.dut%0d.q%0d", k, i), dut_q(k, i), 32'h0);
    @(negedge CLK) RST = 1'b0;

    // reset clears storage and Q mid-operation
    idle(); wr(0, 5, 32'hDEADBEEF); step();
    idle(); rd(0, 5); rd(1, 5); rd(2, 5); step();
    chk("pre_rst.q0", dut_q(0, 0), 32'hDEADBEEF);
    rst_pulse();
    idle(); rd(0, 5); step();
    chk("post_rst.q0", dut_q(0, 0), 32'h0);

    // latency and hold
    idle(); wr(0, 3, 32'h12345678); step();
    idle(); rd(1, 3); step();
    chk("lat.q1", dut_q(0, 1), 32'h12345678);
    idle(); ra[5 +: 5] = 5'd7; step();
    chk("hold.a.q1", dut_q(0, 1), 32'h12345678);
    chk("hold.b.q1", dut_q(1, 1), 32'h12345678);

    // bypass vs read-first
    idle(); wr(0, 9, 32'h11); step();
    idle(); wr(0, 9, 32'hA5A5A5A5); rd(2, 9); step();
    chk("byp.a.q2", dut_q(0, 2), 32'hA5A5A5A5);
    chk("byp.b.q2", dut_q(1, 2), 32'h11);

    // zero register
    idle(); wr(0, 0, 32'hFFFFFFFF); step();
    idle(); rd(0, 0); step();
    chk("zero.a.q0", dut_q(0, 0), 32'h0);
    chk("zero.b.q0", dut_q(1, 0), 32'hFFFFFFFF);

    // write conflict, same-cycle bypassed read
    idle(); wr(0, 4, 32'h1); wr(1, 4, 32'h2); rd(0, 4); step();
    chk("conf.byp.a.q0", dut_q(0, 0), 32'h2);
    idle(); rd(1, 4); step();
    chk("conf.a.q1", dut_q(0, 1), 32'h2);
    chk("conf.b.q1", dut_q(1, 1), 32'h2);

    // out of range on the 24-deep instance, parallel reads
    idle(); wr(0, 30, 32'h55); step();
    idle(); rd(1, 30); step();
    chk("oor.b.q1", dut_q(1, 1), 32'h0);
    idle(); wr(1, 12, 32'h77); step();
    idle(); rd(0, 12); rd(1, 12); rd(2, 12); step();
    for (int i = 0; i < 3; i++)
      chk($sformatf("par.b.q%0d", i), dut_q(1, i), 32'h77);

    // random traffic, clustered addresses to provoke conflicts and bypasses
    for (int n = 0; n < 400; n++) begin
      we = 2'($urandom);
      re = 3'($urandom);
      for (int j = 0; j < 2; j++) begin
        a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
        wa[j*5 +: 5] = 5'(a);
        d[j*32 +: 32] = $urandom;
      end
      for (int i = 0; i < 3; i++) begin
        a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
        ra[i*5 +: 5] = 5'(a);
      end
      step();
      if ($urandom_range(0, 63) == 0) rst_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
